// File: rtl/bf_mem_responder_if.sv
// Core and host signal bundle for bf_mem_responder: fetch, data read/write,
// program load, and the two host byte streams.
interface bf_mem_responder_if #(
    parameter int unsigned PROG_AW = 12
);
    logic [11:0]        pc;
    logic               op_r_req;
    logic [7:0]         op;
    logic               op_den;
    logic [11:0]        dp_adr;
    logic               data_r_req;
    logic               data_r_sel;
    logic [7:0]         data_in;
    logic               data_den;
    logic [7:0]         data_out;
    logic               data_w_req;
    logic               data_w_sel;
    logic               data_w_wait;
    logic               prog_we;
    logic [PROG_AW-1:0] prog_adr;
    logic [7:0]         prog_data;
    logic               in_valid;
    logic [7:0]         in_data;
    logic               in_ready;
    logic               out_valid;
    logic [7:0]         out_data;
    logic               out_ready;
    logic               in_eof;

    modport master (
        output pc, op_r_req, dp_adr, data_r_req, data_r_sel, data_out, data_w_req, data_w_sel,
               prog_we, prog_adr, prog_data, in_valid, in_data, out_ready, in_eof,
        input  op, op_den, data_in, data_den, data_w_wait, in_ready, out_valid, out_data
    );

    modport slave (
        input  pc, op_r_req, dp_adr, data_r_req, data_r_sel, data_out, data_w_req, data_w_sel,
               prog_we, prog_adr, prog_data, in_valid, in_data, out_ready, in_eof,
        output op, op_den, data_in, data_den, data_w_wait, in_ready, out_valid, out_data
    );
endinterface

// File: rtl/bf_mem_responder.sv
// Program/data RAM and character I/O FIFOs serving the brainfuck core.
// Optional BF_IN_EOF_EN: an input read on an empty FIFO completes with 8'h00 when in_eof=1.
module bf_mem_responder #(
    parameter int unsigned PROG_AW    = 12,
    parameter int unsigned DATA_AW    = 12,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_rst,
    bf_mem_responder_if.slave bus
);
    localparam int unsigned FAW = $clog2(FIFO_DEPTH);

    typedef logic [FAW:0] ptr_t;
    typedef enum logic [0:0] {RdIdle, RdWaitIn} rd_state_e;

    logic [7:0] prog_mem [2**PROG_AW];
    logic [7:0] data_mem [2**DATA_AW];
    logic [7:0] in_mem   [FIFO_DEPTH];
    logic [7:0] out_mem  [FIFO_DEPTH];

    logic               fetch_pend_q, fetch_pend_d;
    logic [PROG_AW-1:0] fetch_adr_q, fetch_adr_d, fetch_adr;
    logic               fetch_go;
    logic [7:0]         op_q, op_d;
    logic               op_den_q, op_den_d;

    rd_state_e          rd_state_q, rd_state_d;
    logic [7:0]         data_in_q, data_in_d;
    logic               data_den_q, data_den_d;
    logic               rd_accept, in_read, in_pop;
    logic [DATA_AW-1:0] dp_adr_t;

    ptr_t in_wr_q, in_wr_d, in_rd_q, in_rd_d;
    ptr_t out_wr_q, out_wr_d, out_rd_q, out_rd_d;
    logic in_full, in_empty, in_push;
    logic out_full, out_empty, out_push, out_pop;

    logic unused_sig;
    assign unused_sig = ^{bus.in_eof, bus.pc, bus.dp_adr};

    assign dp_adr_t = bus.dp_adr[DATA_AW-1:0];

    assign in_empty  = (in_wr_q == in_rd_q);
    assign in_full   = (in_wr_q[FAW] != in_rd_q[FAW]) && (in_wr_q[FAW-1:0] == in_rd_q[FAW-1:0]);
    assign out_empty = (out_wr_q == out_rd_q);
    assign out_full  = (out_wr_q[FAW] != out_rd_q[FAW]) &&
                       (out_wr_q[FAW-1:0] == out_rd_q[FAW-1:0]);

    assign in_push  = bus.in_valid & ~in_full;
    assign out_push = bus.data_w_req & bus.data_w_sel & ~out_full;
    assign out_pop  = ~out_empty & bus.out_ready;

    assign bus.in_ready    = ~in_full;
    assign bus.out_valid   = ~out_empty;
    assign bus.out_data    = out_empty ? 8'h00 : out_mem[out_rd_q[FAW-1:0]];
    assign bus.data_w_wait = bus.data_w_req & bus.data_w_sel & out_full;
    assign bus.op          = op_q;
    assign bus.op_den      = op_den_q;
    assign bus.data_in     = data_in_q;
    assign bus.data_den    = data_den_q;

    // A fresh request is served in its own cycle; the pending register only
    // carries it across cycles where the host owns the program RAM port.
    always_comb begin
        fetch_adr    = bus.op_r_req ? bus.pc[PROG_AW-1:0] : fetch_adr_q;
        fetch_go     = (bus.op_r_req | fetch_pend_q) & ~bus.prog_we & ~s_rst;
        fetch_pend_d = fetch_pend_q;
        fetch_adr_d  = fetch_adr_q;
        op_d         = op_q;
        op_den_d     = fetch_go;
        if (s_rst) begin
            fetch_pend_d = 1'b0;
        end else if (bus.op_r_req | fetch_pend_q) begin
            fetch_pend_d = bus.prog_we;
            fetch_adr_d  = fetch_adr;
        end
        if (fetch_go) begin
            op_d = prog_mem[fetch_adr];
        end
    end

    // The data_den term keeps a request still high in its response cycle from
    // being taken as a second read.
    always_comb begin
        rd_accept  = bus.data_r_req & (rd_state_q == RdIdle) & ~data_den_q & ~s_rst;
        in_read    = (rd_accept & bus.data_r_sel) | (rd_state_q == RdWaitIn);
        rd_state_d = rd_state_q;
        data_in_d  = data_in_q;
        data_den_d = 1'b0;
        in_pop     = 1'b0;
        if (s_rst) begin
            rd_state_d = RdIdle;
        end else if (rd_accept && !bus.data_r_sel) begin
            data_in_d  = data_mem[dp_adr_t];
            data_den_d = 1'b1;
        end else if (in_read) begin
            if (!in_empty) begin
                data_in_d  = in_mem[in_rd_q[FAW-1:0]];
                data_den_d = 1'b1;
                in_pop     = 1'b1;
                rd_state_d = RdIdle;
`ifdef BF_IN_EOF_EN
            end else if (bus.in_eof) begin
                data_in_d  = 8'h00;
                data_den_d = 1'b1;
                rd_state_d = RdIdle;
`endif
            end else begin
                rd_state_d = RdWaitIn;
            end
        end
    end

    always_comb begin
        in_wr_d  = s_rst ? '0 : in_wr_q + ptr_t'(in_push);
        in_rd_d  = s_rst ? '0 : in_rd_q + ptr_t'(in_pop);
        out_wr_d = s_rst ? '0 : out_wr_q + ptr_t'(out_push);
        out_rd_d = s_rst ? '0 : out_rd_q + ptr_t'(out_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pend_q <= 1'b0;
            fetch_adr_q  <= '0;
            op_q         <= '0;
            op_den_q     <= 1'b0;
            rd_state_q   <= RdIdle;
            data_in_q    <= '0;
            data_den_q   <= 1'b0;
            in_wr_q      <= '0;
            in_rd_q      <= '0;
            out_wr_q     <= '0;
            out_rd_q     <= '0;
        end else begin
            fetch_pend_q <= fetch_pend_d;
            fetch_adr_q  <= fetch_adr_d;
            op_q         <= op_d;
            op_den_q     <= op_den_d;
            rd_state_q   <= rd_state_d;
            data_in_q    <= data_in_d;
            data_den_q   <= data_den_d;
            in_wr_q      <= in_wr_d;
            in_rd_q      <= in_rd_d;
            out_wr_q     <= out_wr_d;
            out_rd_q     <= out_rd_d;
        end
    end

    // Storage is not reset; s_rst only moves FIFO pointers.
    always_ff @(posedge clk) begin
        if (bus.prog_we) begin
            prog_mem[bus.prog_adr] <= bus.prog_data;
        end
        if (bus.data_w_req && !bus.data_w_sel) begin
            data_mem[dp_adr_t] <= bus.data_out;
        end
        if (in_push) begin
            in_mem[in_wr_q[FAW-1:0]] <= bus.in_data;
        end
        if (out_push) begin
            out_mem[out_wr_q[FAW-1:0]] <= bus.data_out;
        end
    end
endmodule

// File: tb/tb_bf_mem_responder.sv
// Directed bench for bf_mem_responder: RAM vector table plus fetch, stream
// and clear sequences. Inputs change 1 ns after the rising edge.
module tb_bf_mem_responder;
    logic clk = 1'b0;
    logic rst;
    logic s_rst;

    always #5 clk = ~clk;

    bf_mem_responder_if #(.PROG_AW(12)) bus ();

    bf_mem_responder #(
        .PROG_AW   (12),
        .DATA_AW   (12),
        .FIFO_DEPTH(4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .s_rst(s_rst),
        .bus  (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [11:0] wadr;
        logic [7:0]  wdata;
        logic [11:0] radr;
        logic [7:0]  exp;
    } ram_vec_t;

    ram_vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        s_rst = 1'b0;
        bus.pc = '0;
        bus.op_r_req = 1'b0;
        bus.dp_adr = '0;
        bus.data_r_req = 1'b0;
        bus.data_r_sel = 1'b0;
        bus.data_out = '0;
        bus.data_w_req = 1'b0;
        bus.data_w_sel = 1'b0;
        bus.prog_we = 1'b0;
        bus.prog_adr = '0;
        bus.prog_data = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        bus.in_eof = 1'b0;

        vecs[0] = '{wadr: 12'h0FF, wdata: 8'h41, radr: 12'h0FF, exp: 8'h41};
        vecs[1] = '{wadr: 12'h000, wdata: 8'h01, radr: 12'h000, exp: 8'h01};
        vecs[2] = '{wadr: 12'hFFF, wdata: 8'hA5, radr: 12'hFFF, exp: 8'hA5};
        vecs[3] = '{wadr: 12'h0FF, wdata: 8'h5A, radr: 12'h0FF, exp: 8'h5A};
        vecs[4] = '{wadr: 12'h123, wdata: 8'h77, radr: 12'h000, exp: 8'h01};
        vecs[5] = '{wadr: 12'h124, wdata: 8'h88, radr: 12'h123, exp: 8'h77};

        tick();
        tick();
        chk("rst_op_den", bus.op_den, 1'b0);
        chk("rst_op", bus.op, 8'h00);
        chk("rst_data_den", bus.data_den, 1'b0);
        chk("rst_data_in", bus.data_in, 8'h00);
        chk("rst_w_wait", bus.data_w_wait, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_data", bus.out_data, 8'h00);
        rst = 1'b0;
        tick();

        // Program load then fetch: op_den one cycle after the request.
        bus.prog_we = 1'b1;
        bus.prog_adr = 12'd5;
        bus.prog_data = 8'h2B;
        tick();
        bus.prog_we = 1'b0;
        bus.op_r_req = 1'b1;
        bus.pc = 12'd5;
        tick();
        bus.op_r_req = 1'b0;
        chk("fetch_den", bus.op_den, 1'b1);
        chk("fetch_op", bus.op, 8'h2B);
        tick();
        chk("fetch_den_single", bus.op_den, 1'b0);

        // prog_we in the request cycle delays op_den by one cycle.
        bus.prog_we = 1'b1;
        bus.prog_adr = 12'd6;
        bus.prog_data = 8'h3C;
        bus.op_r_req = 1'b1;
        bus.pc = 12'd6;
        tick();
        bus.prog_we = 1'b0;
        bus.op_r_req = 1'b0;
        chk("fetch_blk_den0", bus.op_den, 1'b0);
        tick();
        chk("fetch_blk_den1", bus.op_den, 1'b1);
        chk("fetch_blk_op", bus.op, 8'h3C);
        tick();
        chk("fetch_blk_den2", bus.op_den, 1'b0);

        // RAM vector table: write, then hold a read across its response cycle.
        for (int i = 0; i < 6; i++) begin
            bus.data_w_req = 1'b1;
            bus.data_w_sel = 1'b0;
            bus.dp_adr = vecs[i].wadr;
            bus.data_out = vecs[i].wdata;
            #1;
            chk($sformatf("ram_wr_wait[%0d]", i), bus.data_w_wait, 1'b0);
            tick();
            bus.data_w_req = 1'b0;
            bus.dp_adr = vecs[i].radr;
            bus.data_r_req = 1'b1;
            bus.data_r_sel = 1'b0;
            tick();
            chk($sformatf("ram_rd_den[%0d]", i), bus.data_den, 1'b1);
            chk($sformatf("ram_rd_data[%0d]", i), bus.data_in, vecs[i].exp);
            tick();
            chk($sformatf("ram_rd_no_repeat[%0d]", i), bus.data_den, 1'b0);
            bus.data_r_req = 1'b0;
            tick();
        end

        // Same-cycle read and write of one address returns the old value.
        bus.dp_adr = 12'h0FF;
        bus.data_out = 8'hC3;
        bus.data_w_req = 1'b1;
        bus.data_w_sel = 1'b0;
        bus.data_r_req = 1'b1;
        bus.data_r_sel = 1'b0;
        tick();
        bus.data_w_req = 1'b0;
        bus.data_r_req = 1'b0;
        chk("rw_same_old", bus.data_in, 8'h5A);
        tick();
        bus.data_r_req = 1'b1;
        tick();
        bus.data_r_req = 1'b0;
        chk("rw_same_new", bus.data_in, 8'hC3);
        tick();

        // Input stall, then data arrives.
        bus.data_r_req = 1'b1;
        bus.data_r_sel = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("in_stall_den", bus.data_den, 1'b0);
        end
        bus.in_valid = 1'b1;
        bus.in_data = 8'h37;
        tick();
        bus.in_valid = 1'b0;
        chk("in_push_den0", bus.data_den, 1'b0);
        tick();
        bus.data_r_req = 1'b0;
        chk("in_den", bus.data_den, 1'b1);
        chk("in_data", bus.data_in, 8'h37);
        tick();
        chk("in_den_single", bus.data_den, 1'b0);

        // Pre-filled input FIFO: two reads in order.
        bus.in_valid = 1'b1;
        bus.in_data = 8'h11;
        tick();
        bus.in_data = 8'h22;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.data_r_req = 1'b1;
            tick();
            bus.data_r_req = 1'b0;
            chk($sformatf("in_fill_den[%0d]", i), bus.data_den, 1'b1);
            chk($sformatf("in_fill_data[%0d]", i), bus.data_in, (i == 0) ? 8'h11 : 8'h22);
            tick();
        end

        // Output backpressure: four writes fill the FIFO, the fifth stalls.
        bus.out_ready = 1'b0;
        bus.data_w_sel = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            bus.data_w_req = 1'b1;
            bus.data_out = 8'(k);
            #1;
            chk($sformatf("out_wr_wait[%0d]", k), bus.data_w_wait, 1'b0);
            tick();
            chk($sformatf("out_valid[%0d]", k), bus.out_valid, 1'b1);
        end
        bus.data_out = 8'd5;
        #1;
        chk("out_full_wait", bus.data_w_wait, 1'b1);
        tick();
        chk("out_full_wait_held", bus.data_w_wait, 1'b1);
        bus.out_ready = 1'b1;
        #1;
        chk("out_pop_no_bypass", bus.data_w_wait, 1'b1);
        chk("out_data[1]", bus.out_data, 8'd1);
        tick();
        bus.out_ready = 1'b0;
        chk("out_wait_drop", bus.data_w_wait, 1'b0);
        tick();
        bus.data_w_req = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            #1;
            chk($sformatf("out_drain_valid[%0d]", k), bus.out_valid, 1'b1);
            chk($sformatf("out_data[%0d]", k), bus.out_data, 8'(k));
            tick();
        end
        chk("out_empty", bus.out_valid, 1'b0);
        bus.out_ready = 1'b0;

        // Leave a byte in the output FIFO and a stalled input read, then clear.
        bus.data_w_req = 1'b1;
        bus.data_out = 8'h99;
        tick();
        bus.data_w_req = 1'b0;
        chk("pre_clr_out_valid", bus.out_valid, 1'b1);
        bus.data_r_req = 1'b1;
        bus.data_r_sel = 1'b1;
        bus.in_eof = 1'b1;
        tick();
        bus.data_r_req = 1'b0;
`ifdef BF_IN_EOF_EN
        chk("eof_den", bus.data_den, 1'b1);
        chk("eof_data", bus.data_in, 8'h00);
        bus.in_eof = 1'b0;
        tick();
        bus.data_r_req = 1'b1;
        tick();
        bus.data_r_req = 1'b0;
`endif
        bus.in_eof = 1'b0;
        chk("pend_den", bus.data_den, 1'b0);
        tick();
        s_rst = 1'b1;
        tick();
        s_rst = 1'b0;
        chk("clr_in_ready", bus.in_ready, 1'b1);
        chk("clr_out_valid", bus.out_valid, 1'b0);
        chk("clr_out_data", bus.out_data, 8'h00);

        // Cleared read stays dead while the input FIFO fills up.
        bus.in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            bus.in_data = 8'(8'h50 + k);
            tick();
            chk($sformatf("clr_no_den[%0d]", k), bus.data_den, 1'b0);
            chk($sformatf("in_ready[%0d]", k), bus.in_ready, (k < 4) ? 1'b1 : 1'b0);
        end
        bus.in_valid = 1'b0;
        tick();
        chk("clr_no_den_late", bus.data_den, 1'b0);
        s_rst = 1'b1;
        tick();
        s_rst = 1'b0;
        chk("clr2_in_ready", bus.in_ready, 1'b1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/bf_mem_responder.md
# bf_mem_responder

Target-side memory and I/O responder for the brainfuck core. It serves the core's three request channels: opcode fetch from program RAM, cell read/write to data RAM, and `,`/`.` character I/O through small input and output FIFOs toward a host stream interface. It also gives the host a program-load write port.

## Interface
- PROG_AW, 12, program RAM address width (2^PROG_AW × 8 bits)
- DATA_AW, 12, data RAM address width (2^DATA_AW × 8 bits)
- FIFO_DEPTH, 4, entries in each of the input and output FIFOs; must be a power of two ≥ 2
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- s_rst  in  1  synchronous clear: drops pending fetch/read and empties both FIFOs; RAM contents are kept
- pc  in  12  fetch address, valid while op_r_req=1
- op_r_req  in  1  single-cycle fetch request
- op  out  8  fetched opcode, valid while op_den=1
- op_den  out  1  single-cycle fetch response
- dp_adr  in  12  data address for read and write
- data_r_req  in  1  read request, held high until data_den
- data_r_sel  in  1  read source: 0 = data RAM, 1 = input FIFO
- data_in  out  8  read data, valid while data_den=1
- data_den  out  1  single-cycle read response
- data_out  in  8  write data
- data_w_req  in  1  write request; held high while data_w_wait=1
- data_w_sel  in  1  write target: 0 = data RAM, 1 = output FIFO
- data_w_wait  out  1  combinational stall for the current write
- prog_we, prog_adr[PROG_AW], prog_data[8]  in  host program-RAM write port
- in_valid, in_data[8]  in; in_ready  out  host → input FIFO stream
- out_valid, out_data[8]  out; out_ready  in  output FIFO → host stream
- in_eof  in  1  host end-of-input flag (used only with BF_IN_EOF_EN)

## Operation
- Fetch
  - op_r_req latches pc[PROG_AW-1:0] into a pending-fetch register.
  - The RAM read happens in the first cycle the register is pending and prog_we=0. prog_we always wins the RAM port.
- Data RAM read (data_r_sel=0)
  - A read is accepted when data_r_req=1, no read is pending, and data_den=0 this cycle.
  - Because of the data_den=0 condition, the request that is still high during the data_den cycle is not re-accepted.
- Input read (data_r_sel=1)
  - Accepted under the same rule as a RAM read; the read then stays pending until the input FIFO is non-empty.
  - The FIFO head is popped in the data_den cycle.
- Data RAM write (data_w_sel=0)
  - Performed in every cycle with data_w_req=1 at dp_adr. data_w_wait is never raised for it.
  - The core's memory-clear sweep (one write per cycle, all addresses) is therefore supported at full rate.
- Output write (data_w_sel=1)
  - data_w_wait = data_w_req & data_w_sel & out_full.
  - data_out is pushed in a cycle with data_w_req=1 and data_w_wait=0.
- Address widths: dp_adr and pc are truncated to DATA_AW and PROG_AW bits; higher bits are ignored.
- Host streams
  - in_ready = !in_full. A push happens when in_valid & in_ready.
  - out_valid = !out_empty. A pop happens when out_valid & out_ready.
- FIFOs use (log2 DEPTH + 1)-bit read/write pointers that wrap modulo 2·DEPTH. Full means the MSBs differ and the low bits are equal.
- Simultaneous events
  - Output FIFO full with a pop in the same cycle: data_w_wait stays 1 that cycle (no bypass).
  - Same-cycle RAM read and write to the same address: the read returns the pre-write value.
- Reset: every output is 0 except in_ready=1. Pending flags and FIFO pointers are cleared.
- rst or s_rst mid-transaction: the pending op_den/data_den is never issued.

## Timing
- op_den: 1 cycle after op_r_req, plus 1 cycle for each cycle prog_we holds the port.
- data_den for RAM: 1 cycle after acceptance.
- data_den for input: 1 cycle after acceptance if the FIFO is non-empty at acceptance; otherwise 1 cycle after the first cycle it is non-empty.
- out_valid rises 1 cycle after a push into an empty output FIFO.
- in_ready falls in the cycle after the DEPTH-th unpopped push.
- data_den, op_den and the FIFO pop are registered. data_w_wait is the only combinational output.

## Configuration
- BF_IN_EOF_EN defined:
  - A pending input read with the input FIFO empty and in_eof=1 completes 1 cycle later with data_in=8'h00.
  - Nothing is popped.
- BF_IN_EOF_EN undefined:
  - in_eof is ignored.
  - An input read stalls indefinitely until data arrives.

## Test plan
- Program load and fetch:
  - Stimulus: prog_we writes 8'h2B at address 5, then op_r_req with pc=5.
  - Response: op=8'h2B with op_den exactly 1 cycle later.
  - Variant: prog_we held high in the same cycle as the request delays op_den by 1 cycle.
- RAM write/read: data_w_req with dp_adr=12'h0FF and data_out=8'h41, then data_r_req held with data_r_sel=0 → a single data_den pulse 1 cycle after acceptance, data_in=8'h41, and no second data_den.
- Input stall: data_r_req with data_r_sel=1 and the FIFO empty → no data_den. Push in_data=8'h37 → data_den with data_in=8'h37 1 cycle after the FIFO becomes non-empty, and the FIFO is empty afterwards.
- Output backpressure:
  - Stimulus: out_ready=0 and 4 writes with data_w_sel=1, then a 5th write.
  - Response: data_w_wait=1 held on the 5th write.
  - Stimulus: pulse out_ready once.
  - Response: data_w_wait drops in the next cycle, and order 1..5 is preserved on out_data.
- Reset mid-read: assert s_rst while an input read is pending → no data_den ever; in_ready=1 and out_valid=0 after the clear.
- BF_IN_EOF_EN: empty FIFO, in_eof=1, input read → data_den 1 cycle after acceptance with data_in=8'h00.
